// File: rtl/downsizing.sv
// AXI-Stream width halver: one 2*W-bit input beat becomes two W-bit output
// beats, upper half first, matching the packing order of the upsizing stage.
module downsizing #(
  parameter int W = 40
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [2*W-1:0] in_tdata,
  input  logic           in_tvalid,
  output logic           in_tready,
  output logic [W-1:0]   out_tdata,
  output logic           out_tvalid,
  input  logic           out_tready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    UPPER = 2'd1,
    LOWER = 2'd2
  } state_t;

  // Handshake: a beat moves on a port exactly in a cycle where valid and ready
  // are both high at the rising edge. in_tready never looks at in_tvalid, and
  // out_tvalid/out_tdata hold steady while out_tvalid & ~out_tready.

  state_t         state, state_d;
  logic [2*W-1:0] data_buf, data_buf_d;
  logic [W-1:0]   out_data_d;
  logic           out_valid_d;
  logic           in_xfer;
  logic           out_xfer;

  // The out_tready -> in_tready path lets LOWER refill without a bubble.
  assign in_tready = aresetn & ((state == EMPTY) | ((state == LOWER) & out_tready));
  assign in_xfer   = in_tvalid & in_tready;
  assign out_xfer  = out_tvalid & out_tready;

  always_comb begin
    state_d    = state;
    data_buf_d = data_buf;
    out_data_d = out_tdata;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          data_buf_d = in_tdata;
          out_data_d = in_tdata[2*W-1:W];
          state_d    = UPPER;
        end
      end
      UPPER: begin
        if (out_xfer) begin
          out_data_d = data_buf[W-1:0];
          state_d    = LOWER;
        end
      end
      LOWER: begin
        if (out_xfer) begin
          if (in_xfer) begin
            data_buf_d = in_tdata;
            out_data_d = in_tdata[2*W-1:W];
            state_d    = UPPER;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= EMPTY;
      data_buf   <= '0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
    end else begin
      state      <= state_d;
      data_buf   <= data_buf_d;
      out_tdata  <= out_data_d;
      out_tvalid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_downsizing.sv
// Directed bench for downsizing: reset, single beat, streaming, backpressure,
// input gaps, mid-operation reset and an upsizing-style loopback.
module tb_downsizing;

  localparam int W = 40;

  logic           aclk;
  logic           aresetn;
  logic [2*W-1:0] in_tdata;
  logic           in_tvalid;
  logic           in_tready;
  logic [W-1:0]   out_tdata;
  logic           out_tvalid;
  logic           out_tready;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int stall_err = 0;

  logic [2*W-1:0] src_q[$];
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   got_q[$];
  int             got_cyc_q[$];
  logic           rdy_trace[$];

  logic           prev_stall = 1'b0;
  logic [W-1:0]   prev_data = '0;

  localparam logic [2*W-1:0] BEAT_A = "ABCDEFGHIJ";
  localparam logic [2*W-1:0] BEAT_K = "KLMNOPQRST";
  localparam logic [2*W-1:0] BEAT_U = "UVWXYZabcd";
  localparam logic [2*W-1:0] BEAT_0 = "0123456789";
  localparam logic [W-1:0]   H_ABCDE = "ABCDE";
  localparam logic [W-1:0]   H_FGHIJ = "FGHIJ";
  localparam logic [W-1:0]   H_01234 = "01234";
  localparam logic [W-1:0]   H_56789 = "56789";

  downsizing #(.W(W)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

  // output monitor: records transfers and watches stall stability
  always @(negedge aclk) begin
    if (aresetn && out_tvalid && out_tready) begin
      got_q.push_back(out_tdata);
      got_cyc_q.push_back(cyc_cnt);
    end
    if (aresetn && prev_stall && (!out_tvalid || out_tdata !== prev_data))
      stall_err = stall_err + 1;
    prev_stall = aresetn & out_tvalid & ~out_tready;
    prev_data  = out_tdata;
  end

  task automatic apply_reset();
    aresetn    = 1'b0;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    out_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  // Source/sink driver. rmode: 0 ready always, 1 alternate from 0, 2 random.
  task automatic run_stream(input int gap_max, input int rmode, input int budget,
                            output bit timed_out);
    int  idx = 0;
    int  n = src_q.size();
    int  gap = 0;
    int  cyc = 0;
    int  phase = 0;
    bit  acc;
    got_q.delete();
    got_cyc_q.delete();
    rdy_trace.delete();
    timed_out = 1'b0;
    if (gap_max > 0) gap = $urandom_range(0, gap_max);
    while ((idx < n || got_q.size() < 2 * n) && cyc < budget) begin
      in_tvalid = (idx < n) && (gap == 0);
      in_tdata  = (idx < n) ? src_q[idx] : '0;
      case (rmode)
        0:       out_tready = 1'b1;
        1:       out_tready = phase[0];
        default: out_tready = 1'($urandom_range(0, 1));
      endcase
      phase++;
      @(negedge aclk);
      rdy_trace.push_back(in_tready);
      acc = in_tvalid & in_tready;
      @(posedge aclk);
      #1;
      if (acc) begin
        idx++;
        gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      end else if (!in_tvalid && gap > 0) begin
        gap--;
      end
      cyc++;
    end
    if (cyc >= budget) timed_out = 1'b1;
    in_tvalid  = 1'b0;
    out_tready = 1'b0;
  endtask

  task automatic build_expected();
    exp_q.delete();
    foreach (src_q[i]) begin
      exp_q.push_back(src_q[i][2*W-1:W]);
      exp_q.push_back(src_q[i][W-1:0]);
    end
  endtask

  task automatic test_reset();
    aresetn    = 1'b0;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    out_tready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_tvalid); end
    checks++;
    if (out_tdata !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", out_tdata); end
    checks++;
    if (in_tready !== 1'b0) begin errors++; $display("FAIL reset_in_tready got=%b want=0", in_tready); end
    @(posedge aclk);
    #1 aresetn = 1'b1;
    #1;
    checks++;
    if (in_tready !== 1'b1) begin errors++; $display("FAIL release_in_tready got=%b want=1", in_tready); end
  endtask

  task automatic test_single_beat();
    in_tdata   = BEAT_A;
    in_tvalid  = 1'b1;
    out_tready = 1'b1;
    @(negedge aclk);
    checks++;
    if (in_tready !== 1'b1) begin errors++; $display("FAIL single_accept got=%b want=1", in_tready); end
    @(posedge aclk);
    #1 in_tvalid = 1'b0;
    @(negedge aclk);
    checks++;
    if (out_tvalid !== 1'b1 || out_tdata !== H_ABCDE)
      begin errors++; $display("FAIL single_upper got=%b/%h want=1/%h", out_tvalid, out_tdata, H_ABCDE); end
    checks++;
    if (in_tready !== 1'b0) begin errors++; $display("FAIL single_upper_ready got=%b want=0", in_tready); end
    @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (out_tvalid !== 1'b1 || out_tdata !== H_FGHIJ)
      begin errors++; $display("FAIL single_lower got=%b/%h want=1/%h", out_tvalid, out_tdata, H_FGHIJ); end
    @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b want=0", out_tvalid); end
    checks++;
    if (out_tdata !== H_FGHIJ) begin errors++; $display("FAIL single_empty_hold got=%h want=%h", out_tdata, H_FGHIJ); end
  endtask

  task automatic test_streaming();
    bit to;
    apply_reset();
    src_q = '{BEAT_A, BEAT_K, BEAT_U};
    build_expected();
    run_stream(0, 0, 200, to);
    checks++;
    if (to) begin errors++; $display("FAIL stream_timeout got=1 want=0"); end
    checks++;
    if (got_q.size() !== 6) begin errors++; $display("FAIL stream_count got=%0d want=6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
      checks++;
      if (got_cyc_q[i] !== got_cyc_q[0] + i)
        begin errors++; $display("FAIL stream_gap[%0d] got=%0d want=%0d", i, got_cyc_q[i], got_cyc_q[0] + i); end
    end
    for (int i = 0; i < rdy_trace.size() && i < 6; i++) begin
      checks++;
      if (rdy_trace[i] !== ((i % 2) == 0))
        begin errors++; $display("FAIL stream_in_tready[%0d] got=%b want=%b", i, rdy_trace[i], (i % 2) == 0); end
    end
  endtask

  task automatic check_scoreboard(input string tag, input bit to, input int stall0);
    checks++;
    if (to) begin errors++; $display("FAIL %s_timeout got=1 want=0", tag); end
    checks++;
    if (got_q.size() !== exp_q.size())
      begin errors++; $display("FAIL %s_count got=%0d want=%0d", tag, got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s_data got=%h want=%h", tag, g, e); end
    end
    checks++;
    if (stall_err !== stall0) begin errors++; $display("FAIL %s_stall_stable got=%0d want=%0d", tag, stall_err, stall0); end
  endtask

  task automatic test_backpressure();
    bit to;
    int s0;
    apply_reset();
    src_q = '{BEAT_A, BEAT_K, BEAT_U, BEAT_0};
    build_expected();
    s0 = stall_err;
    run_stream(0, 1, 400, to);
    check_scoreboard("bp_alt", to, s0);
    src_q = '{BEAT_U, BEAT_0, BEAT_A, BEAT_K, BEAT_A};
    build_expected();
    s0 = stall_err;
    run_stream(0, 2, 400, to);
    check_scoreboard("bp_rand", to, s0);
  endtask

  task automatic test_gaps();
    bit to;
    int s0;
    logic [63:0] r0, r1;
    apply_reset();
    src_q.delete();
    for (int i = 0; i < 6; i++) begin
      r0 = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      src_q.push_back({r0[W-1:0], r1[W-1:0]});
    end
    build_expected();
    s0 = stall_err;
    run_stream(5, 2, 600, to);
    check_scoreboard("gaps", to, s0);
  endtask

  task automatic test_mid_reset();
    apply_reset();
    in_tdata   = BEAT_A;
    in_tvalid  = 1'b1;
    out_tready = 1'b1;
    @(posedge aclk);
    #1 in_tvalid = 1'b0;
    @(posedge aclk);
    #1 out_tready = 1'b0;
    @(negedge aclk);
    checks++;
    if (out_tvalid !== 1'b1 || out_tdata !== H_FGHIJ)
      begin errors++; $display("FAIL midrst_lower got=%b/%h want=1/%h", out_tvalid, out_tdata, H_FGHIJ); end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", out_tvalid); end
    checks++;
    if (in_tready !== 1'b0) begin errors++; $display("FAIL midrst_in_tready got=%b want=0", in_tready); end
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    out_tready = 1'b1;
    @(negedge aclk);
    checks++;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_no_partial got=%b want=0", out_tvalid); end
    in_tdata  = BEAT_0;
    in_tvalid = 1'b1;
    @(posedge aclk);
    #1 in_tvalid = 1'b0;
    @(negedge aclk);
    checks++;
    if (out_tvalid !== 1'b1 || out_tdata !== H_01234)
      begin errors++; $display("FAIL midrst_upper got=%b/%h want=1/%h", out_tvalid, out_tdata, H_01234); end
    @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (out_tvalid !== 1'b1 || out_tdata !== H_56789)
      begin errors++; $display("FAIL midrst_lower2 got=%b/%h want=1/%h", out_tvalid, out_tdata, H_56789); end
    @(posedge aclk);
    #1 out_tready = 1'b0;
  endtask

  // Narrow words are packed upper-first as the upsizing stage would.
  task automatic test_loopback();
    bit to;
    int s0;
    logic [63:0] r;
    logic [W-1:0] words[8];
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      r = {$urandom, $urandom};
      words[i] = r[W-1:0];
    end
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back({words[2*i], words[2*i+1]});
    for (int i = 0; i < 8; i++) exp_q.push_back(words[i]);
    s0 = stall_err;
    run_stream(0, 2, 1000, to);
    check_scoreboard("loop", to, s0);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_streaming();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    test_loopback();
    repeat (2) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
